op_tx_scheduler: RTL and testbench

Transmit-side controller for the NeXT sound/keyboard serial link. It latches pending send requests (power-on S1 packet, audio sample request, keyboard/mouse data) and waits for a send slot from the receiver. It then picks one request by fixed priority, builds the 40-bit op packet and shifts it out MSB-first on the link bit clock. It sits between the request sources / keyboard buffer and the link output driver.

---
 rtl/op_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_op_tx_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_tx_scheduler.sv
// Transmit scheduler for the NeXT sound/keyboard link: latches send requests,
// picks one by fixed priority when a slot opens and shifts the 40-bit op packet out MSB-first.
module op_tx_scheduler #(
    parameter int PACKET_BITS = 40,
    parameter int TURNAROUND  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_tick,
    input  logic        can_send,
    input  logic        power_on_req,
    input  logic        audio_req,
    input  logic        kbd_ready,
    input  logic        kbd_is_mouse,
    input  logic [15:0] kbd_data,
    output logic        kbd_ack,
    output logic        tx_out,
    output logic        tx_active,
    output logic        busy,
    output logic        audio_overrun
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PON,
        SRC_AUD,
        SRC_KBD
    } src_t;

    localparam logic [PACKET_BITS-1:0] PON_PACKET = 40'hC6_71_00_00_00;
    localparam logic [PACKET_BITS-1:0] AUD_PACKET = 40'h07_00_00_00_00;
    localparam logic [5:0] LAST_BIT = 6'(PACKET_BITS);
    localparam logic [3:0] GAP_LAST = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);

    state_t                 state, state_n;
    src_t                   src;
    logic                   pon_p, pon_n;
    logic                   aud_p, aud_n;
    logic [PACKET_BITS-1:0] sr, sr_n;
    logic [5:0]             bit_cnt, bit_cnt_n;
    logic [3:0]             gap_cnt, gap_cnt_n;
    logic                   overrun_n;
    logic                   kbd_ack_n;

    // Selection only in IDLE with an open slot; pending flags outrank the keyboard level.
    always_comb begin
        src = SRC_NONE;
        if (state == IDLE && can_send) begin
            if (pon_p)          src = SRC_PON;
            else if (aud_p)     src = SRC_AUD;
            else if (kbd_ready) src = SRC_KBD;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        case (state)
            IDLE: begin
                if (src != SRC_NONE) begin
                    case (src)
                        SRC_PON: sr_n = PON_PACKET;
                        SRC_AUD: sr_n = AUD_PACKET;
                        default: sr_n = {8'hC6, (kbd_is_mouse ? 8'h01 : 8'h10), 8'h00, kbd_data};
                    endcase
                    bit_cnt_n = '0;
                    gap_cnt_n = '0;
                    state_n   = (TURNAROUND == 0) ? SHIFT : GAP;
                end
            end
            GAP: begin
                if (bit_tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt_n = '0;
                        state_n   = SHIFT;
                    end else begin
                        gap_cnt_n = gap_cnt + 4'd1;
                    end
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    sr_n      = {sr[PACKET_BITS-2:0], 1'b0};
                    bit_cnt_n = bit_cnt + 6'd1;
                    if (bit_cnt_n == LAST_BIT) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A strobe landing in the same cycle as its selection re-arms the flag.
    // An audio request that coincides with its own selection is not a lost request.
    always_comb begin
        pon_n     = (pon_p && src != SRC_PON) || power_on_req;
        aud_n     = (aud_p && src != SRC_AUD) || audio_req;
        overrun_n = audio_req && aud_p && src != SRC_AUD;
        kbd_ack_n = (src == SRC_KBD);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pon_p         <= 1'b0;
            aud_p         <= 1'b0;
            sr            <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            kbd_ack       <= 1'b0;
            tx_out        <= 1'b0;
            tx_active     <= 1'b0;
            busy          <= 1'b0;
            audio_overrun <= 1'b0;
        end else begin
            state         <= state_n;
            pon_p         <= pon_n;
            aud_p         <= aud_n;
            sr            <= sr_n;
            bit_cnt       <= bit_cnt_n;
            gap_cnt       <= gap_cnt_n;
            kbd_ack       <= kbd_ack_n;
            // Outputs are registered from next-state values so they line up with the state they describe.
            tx_out        <= (state_n == SHIFT) ? sr_n[PACKET_BITS-1] : 1'b0;
            tx_active     <= (state_n == SHIFT);
            busy          <= (state_n != IDLE);
            audio_overrun <= overrun_n;
        end
    end

endmodule

// File: tb/tb_op_tx_scheduler.sv
// Directed self-checking bench for op_tx_scheduler: captures serial packets and
// compares them, plus handshake pulses, against hand-computed values.
module tb_op_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_tick;
    logic        can_send;
    logic        power_on_req;
    logic        audio_req;
    logic        kbd_ready;
    logic        kbd_is_mouse;
    logic [15:0] kbd_data;
    logic        kbd_ack;
    logic        tx_out;
    logic        tx_active;
    logic        busy;
    logic        audio_overrun;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int ovr_cnt = 0;

    op_tx_scheduler #(.PACKET_BITS(40), .TURNAROUND(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bit_tick     (bit_tick),
        .can_send     (can_send),
        .power_on_req (power_on_req),
        .audio_req    (audio_req),
        .kbd_ready    (kbd_ready),
        .kbd_is_mouse (kbd_is_mouse),
        .kbd_data     (kbd_data),
        .kbd_ack      (kbd_ack),
        .tx_out       (tx_out),
        .tx_active    (tx_active),
        .busy         (busy),
        .audio_overrun(audio_overrun)
    );

    always #5 clk = ~clk;

    // One bit_tick every fourth clock.
    initial begin
        int div = 0;
        bit_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            bit_tick = (div == 0);
        end
    end

    always @(negedge clk) begin
        if (kbd_ack)       ack_cnt <= ack_cnt + 1;
        if (audio_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_slot();
        can_send = 1'b1;
        step();
        can_send = 1'b0;
    endtask

    task automatic pulse_power_on();
        power_on_req = 1'b1;
        step();
        power_on_req = 1'b0;
    endtask

    task automatic pulse_audio();
        audio_req = 1'b1;
        step();
        audio_req = 1'b0;
    endtask

    // Records tx_out on every bit_tick while tx_active; returns at the negedge of the 40th tick.
    task automatic capture(output logic [39:0] pkt, output int ticks);
        int bits = 0;
        int cyc  = 0;
        pkt   = '0;
        ticks = 0;
        while (bits < 40 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (busy && bit_tick) ticks++;
            if (tx_active && bit_tick) begin
                pkt = {pkt[38:0], tx_out};
                bits++;
            end
        end
        checks++;
        if (bits != 40) begin
            errors++;
            $display("FAIL capture_timeout: got %0d bits, expected 40", bits);
        end
    endtask

    task automatic check_idle_after(string name);
        @(negedge clk);
        checks++;
        if ({busy, tx_active, tx_out} !== 3'b000) begin
            errors++;
            $display("FAIL %s_end: busy/tx_active/tx_out=%b, expected 000", name, {busy, tx_active, tx_out});
        end
    endtask

    task automatic check_pkt(string name, logic [39:0] got, logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: packet %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        can_send     = 1'b0;
        power_on_req = 1'b0;
        audio_req    = 1'b0;
        kbd_ready    = 1'b0;
        kbd_is_mouse = 1'b0;
        kbd_data     = 16'h0000;
        step();
        step();
        checks++;
        if ({tx_out, tx_active, busy, kbd_ack, audio_overrun} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: %b, expected 00000",
                     {tx_out, tx_active, busy, kbd_ack, audio_overrun});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_power_on();
        logic [39:0] pkt;
        int ticks;
        int ack0 = ack_cnt;
        pulse_power_on();
        send_slot();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pon_busy_start: busy=%b, expected 1", busy);
        end
        capture(pkt, ticks);
        check_pkt("pon_packet", pkt, 40'hC671000000);
        checks++;
        if (ticks != 44) begin
            errors++;
            $display("FAIL pon_busy_ticks: %0d ticks while busy, expected 44", ticks);
        end
        check_idle_after("pon");
        checks++;
        if (ack_cnt != ack0) begin
            errors++;
            $display("FAIL pon_no_ack: %0d kbd_ack pulses, expected 0", ack_cnt - ack0);
        end
    endtask

    task automatic test_priority();
        logic [39:0] pkt;
        int ticks;
        int ack0;
        pulse_audio();
        pulse_power_on();
        kbd_ready    = 1'b1;
        kbd_is_mouse = 1'b0;
        kbd_data     = 16'h1234;
        ack0 = ack_cnt;
        send_slot();
        capture(pkt, ticks);
        check_pkt("prio_first_pon", pkt, 40'hC671000000);
        check_idle_after("prio_first");
        // Back-to-back: slot offered in the very first IDLE cycle.
        send_slot();
        capture(pkt, ticks);
        check_pkt("prio_second_aud", pkt, 40'h0700000000);
        check_idle_after("prio_second");
        checks++;
        if (ack_cnt != ack0) begin
            errors++;
            $display("FAIL prio_early_ack: %0d kbd_ack pulses before kbd packet, expected 0", ack_cnt - ack0);
        end
        send_slot();
        checks++;
        if (kbd_ack !== 1'b1) begin
            errors++;
            $display("FAIL prio_ack_pulse: kbd_ack=%b at N+1, expected 1", kbd_ack);
        end
        kbd_ready = 1'b0;
        step();
        checks++;
        if (kbd_ack !== 1'b0) begin
            errors++;
            $display("FAIL prio_ack_width: kbd_ack=%b at N+2, expected 0", kbd_ack);
        end
        capture(pkt, ticks);
        check_pkt("prio_third_kbd", pkt, 40'hC610001234);
        check_idle_after("prio_third");
        checks++;
        if (ack_cnt - ack0 != 1) begin
            errors++;
            $display("FAIL prio_ack_count: %0d kbd_ack pulses, expected 1", ack_cnt - ack0);
        end
    endtask

    task automatic test_mouse();
        logic [39:0] pkt;
        int ticks;
        kbd_ready    = 1'b1;
        kbd_is_mouse = 1'b1;
        kbd_data     = 16'hABCD;
        send_slot();
        kbd_ready    = 1'b0;
        kbd_is_mouse = 1'b0;
        kbd_data     = 16'h0000;
        capture(pkt, ticks);
        check_pkt("mouse_packet", pkt, 40'hC60100ABCD);
        check_idle_after("mouse");
    endtask

    task automatic test_audio_merge();
        logic [39:0] pkt;
        logic seen_busy = 1'b0;
        int ticks;
        int ovr0 = ovr_cnt;
        pulse_audio();
        step();
        audio_req = 1'b1;
        step();
        audio_req = 1'b0;
        checks++;
        if (audio_overrun !== 1'b1) begin
            errors++;
            $display("FAIL merge_overrun_timing: audio_overrun=%b after second request, expected 1", audio_overrun);
        end
        step();
        step();
        checks++;
        if (ovr_cnt - ovr0 != 1) begin
            errors++;
            $display("FAIL merge_overrun_count: %0d pulses, expected 1", ovr_cnt - ovr0);
        end
        send_slot();
        capture(pkt, ticks);
        check_pkt("merge_audio", pkt, 40'h0700000000);
        check_idle_after("merge");
        send_slot();
        repeat (20) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        checks++;
        if (seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL merge_single_send: busy=%b after second slot, expected 0", seen_busy);
        end
    endtask

    task automatic test_ignore_slot();
        logic [39:0] pkt;
        logic seen_busy = 1'b0;
        int ticks;
        pulse_power_on();
        send_slot();
        fork
            capture(pkt, ticks);
            begin
                int guard = 0;
                step();
                pulse_audio();
                send_slot();
                while (!tx_active && guard < 500) begin
                    step();
                    guard++;
                end
                repeat (10) step();
                send_slot();
            end
        join
        check_pkt("ignore_pon", pkt, 40'hC671000000);
        check_idle_after("ignore");
        repeat (10) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        checks++;
        if (seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart: busy=%b without a new slot, expected 0", seen_busy);
        end
        send_slot();
        capture(pkt, ticks);
        check_pkt("ignore_pending_audio", pkt, 40'h0700000000);
        check_idle_after("ignore_audio");
    endtask

    task automatic test_reset_mid_packet();
        logic seen_busy = 1'b0;
        int bits = 0;
        int cyc  = 0;
        kbd_ready = 1'b1;
        kbd_data  = 16'h5A5A;
        send_slot();
        kbd_ready = 1'b0;
        while (bits < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (tx_active && bit_tick) bits++;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_out, tx_active, busy, kbd_ack, audio_overrun} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_outputs: %b after %0d bits, expected 00000",
                     {tx_out, tx_active, busy, kbd_ack, audio_overrun}, bits);
        end
        step();
        step();
        reset = 1'b0;
        step();
        send_slot();
        repeat (20) begin
            @(negedge clk);
            seen_busy |= busy | tx_active;
        end
        checks++;
        if (seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_resend: busy/tx_active seen=%b, expected 0", seen_busy);
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_priority();
        test_mouse();
        test_audio_merge();
        test_ignore_slot();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
